gray_counter: RTL and testbench

- Synchronous, enable-gated up-counter whose visible count is Gray-coded.
- Sticky overflow flag raised on the first wrap from the last Gray code back to zero.
- Used as a small sequencing/timestamp primitive in single-clock datapaths.
- Default width is 3 bits, giving the sequence 000,001,011,010,110,111,101,100.

---
 rtl/gray_counter.sv | 50 +++++
 tb/tb_gray_counter.sv | 116 +++++++++++
 2 files changed

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter
// Description : Enable-gated up-counter with registered Gray-coded output and
//               a sticky overflow flag set on wrap to zero. Defining
//               GRAY_COUNTER_BIN_OUT_EN adds the BinOut port (binary count).
// Revision    : 1.0 - initial release
// ============================================================================
module gray_counter #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
`ifdef GRAY_COUNTER_BIN_OUT_EN
    output logic [WIDTH-1:0] BinOut,
`endif
    output logic [WIDTH-1:0] Output,
    output logic             Overflow
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] g;
    logic             ovf;
    logic [WIDTH-1:0] cnt_next;

    assign cnt_next = cnt + 1'b1;

    // Gray code is registered from the next binary value so Output never glitches.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt <= '0;
            g   <= '0;
            ovf <= 1'b0;
        end else if (En) begin
            cnt <= cnt_next;
            g   <= cnt_next ^ (cnt_next >> 1);
            if (&cnt)
                ovf <= 1'b1;
        end
    end

    assign Output   = g;
    assign Overflow = ovf;
`ifdef GRAY_COUNTER_BIN_OUT_EN
    assign BinOut   = cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_counter
// Description : Directed self-checking bench for gray_counter (WIDTH = 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter;

    localparam int WIDTH = 3;

    logic             Clk;
    logic             Reset;
    logic             En;
    logic [WIDTH-1:0] Output;
    logic             Overflow;
`ifdef GRAY_COUNTER_BIN_OUT_EN
    logic [WIDTH-1:0] BinOut;
`endif

    int n_cmp;
    int n_err;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] gseq [8];

    gray_counter #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
`ifdef GRAY_COUNTER_BIN_OUT_EN
        .BinOut   (BinOut),
`endif
        .Output   (Output),
        .Overflow (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One edge, then check Output/Overflow and, when counting, the one-bit-change property.
    task automatic step_check(input string tag, input logic [WIDTH-1:0] exp_g,
                              input logic exp_ovf, input logic check_step);
        prev = Output;
        tick();
        check_eq({tag, ".out"}, 32'(Output), 32'(exp_g));
        check_eq({tag, ".ovf"}, 32'(Overflow), 32'(exp_ovf));
        if (check_step)
            check_eq({tag, ".onebit"}, 32'($countones(prev ^ Output)), 32'd1);
`ifdef GRAY_COUNTER_BIN_OUT_EN
        check_eq({tag, ".bin"}, 32'(BinOut ^ (BinOut >> 1)), 32'(exp_g));
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        gseq[0] = 3'b000; gseq[1] = 3'b001; gseq[2] = 3'b011; gseq[3] = 3'b010;
        gseq[4] = 3'b110; gseq[5] = 3'b111; gseq[6] = 3'b101; gseq[7] = 3'b100;

        Reset = 1'b1;
        En    = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        check_eq("rst.out", 32'(Output), 32'd0);
        check_eq("rst.ovf", 32'(Overflow), 32'd0);

        Reset = 1'b0;
        for (int i = 0; i < 3; i++) step_check("idle", 3'b000, 1'b0, 1'b0);

        En = 1'b1;
        for (int i = 1; i < 8; i++) step_check("count", gseq[i], 1'b0, 1'b1);
        step_check("wrap", 3'b000, 1'b1, 1'b1);
        for (int i = 1; i < 6; i++) step_check("sticky", gseq[i], 1'b1, 1'b1);
        step_check("to_wrap", 3'b101, 1'b1, 1'b1);
        step_check("to_wrap", 3'b100, 1'b1, 1'b1);
        step_check("wrap2", 3'b000, 1'b1, 1'b1);

        step_check("en_on", 3'b001, 1'b1, 1'b1);
        step_check("en_on", 3'b011, 1'b1, 1'b1);
        En = 1'b0;
        step_check("en_off", 3'b011, 1'b1, 1'b0);
        step_check("en_off", 3'b011, 1'b1, 1'b0);
        En = 1'b1;
        step_check("en_resume", 3'b010, 1'b1, 1'b1);
        step_check("en_resume", 3'b110, 1'b1, 1'b1);

        Reset = 1'b1;
        En    = 1'b0;
        step_check("mid_rst", 3'b000, 1'b0, 1'b0);
        Reset = 1'b0;
        En    = 1'b1;
        step_check("post_rst", 3'b001, 1'b0, 1'b1);
        step_check("post_rst", 3'b011, 1'b0, 1'b1);

        Reset = 1'b1;
        step_check("rst_en", 3'b000, 1'b0, 1'b0);
        Reset = 1'b0;
        step_check("after_rst_en", 3'b001, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
